// File: rtl/fetch_pc_ctrl.sv
// Next-PC sequencer: owns the PC, issues instruction fetches to a variable
// latency memory, and presents the fetched word to decode over valid/ready.
// Redirects to TRAP_VEC on flush, illegal select or a misaligned target.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | one cycle after reset, loads the fetch address from the PC
// S_FETCH  | request outstanding at addr_q, waiting for ack
// S_DRAIN  | flushed while a request was in flight; wait for ack, drop data
// S_DELIVER| instruction held on o_instr until consumer accepts it
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_pc_imm,
  input  logic [31:0] i_alu_data,
  input  logic        i_instr_ready,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_trap,
  output logic [31:0] o_trap_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] pc_four;
  logic [31:0] raw_tgt;

  assign pc_four = pc_q + 32'd4;

  // Raw redirect target selected by the control unit (JALR clears bit 0).
  always_comb begin
    raw_tgt = pc_four;
    case (i_pc_sel)
      2'b00:   raw_tgt = pc_four;
      2'b01:   raw_tgt = i_pc_imm;
      2'b10:   raw_tgt = i_alu_data & 32'hFFFF_FFFE;
      default: raw_tgt = TRAP_VEC;
    endcase
  end

  // Next-state, PC and trap logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          pc_d   = TRAP_VEC;
          addr_d = TRAP_VEC;
        end else begin
          addr_d = pc_q;
        end
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          if (i_flush) begin
            // data dropped; re-request at the trap vector right away
            pc_d   = TRAP_VEC;
            addr_d = TRAP_VEC;
          end else begin
            instr_d = i_imem_rdata;
            state_d = S_DELIVER;
          end
        end else if (i_flush) begin
          // request cannot be withdrawn; keep addr_q until ack
          pc_d    = TRAP_VEC;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_imem_ack) begin
          addr_d  = pc_q;
          state_d = S_FETCH;
        end
      end
      S_DELIVER: begin
        if (i_flush) begin
          pc_d    = TRAP_VEC;
          addr_d  = TRAP_VEC;
          state_d = S_FETCH;
        end else if (i_instr_ready) begin
          if (i_pc_sel == 2'b11) begin
            trap_d      = 1'b1;
            trap_addr_d = pc_q;
            pc_d        = TRAP_VEC;
          end else if (raw_tgt[1:0] != 2'b00) begin
            trap_d      = 1'b1;
            trap_addr_d = raw_tgt;
            pc_d        = TRAP_VEC;
          end else begin
            pc_d = raw_tgt;
          end
          addr_d  = pc_d;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      instr_q     <= 32'd0;
      trap_q      <= 1'b0;
      trap_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign o_imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign o_imem_addr   = addr_q;
  assign o_instr_valid = (state_q == S_DELIVER);
  assign o_instr       = instr_q;
  assign o_pc          = pc_q;
  assign o_pc_four     = pc_four;
  assign o_trap        = trap_q;
  assign o_trap_addr   = trap_addr_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: a table of fetch/deliver records chained
// through the expected next-fetch address, then hand sequences for flush,
// drain and asynchronous reset.
module tb_fetch_pc_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_flush;
  logic [1:0]  i_pc_sel;
  logic [31:0] i_pc_imm;
  logic [31:0] i_alu_data;
  logic        i_instr_ready;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_trap;
  logic [31:0] o_trap_addr;

  fetch_pc_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_pc_sel(i_pc_sel), .i_pc_imm(i_pc_imm), .i_alu_data(i_alu_data),
    .i_instr_ready(i_instr_ready), .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata), .o_instr_valid(o_instr_valid),
    .o_instr(o_instr), .o_pc(o_pc), .o_pc_four(o_pc_four),
    .o_trap(o_trap), .o_trap_addr(o_trap_addr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;   // expected fetch address
    logic [31:0] rdata;  // word returned by memory
    int          ack_dly;
    int          rdy_dly;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] nxt;    // expected next fetch address
    logic        trap;
    logic [31:0] taddr;
  } vec_t;

  vec_t        vecs[13];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_ta = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (o_imem_req !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("req_seen", {31'd0, o_imem_req}, 32'd1);
    chk("fetch_addr", o_imem_addr, v.addr);
    for (int k = 0; k < v.ack_dly; k++) begin
      @(negedge i_clk);
      chk("req_hold", {31'd0, o_imem_req}, 32'd1);
      chk("addr_hold", o_imem_addr, v.addr);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = v.rdata;
    @(negedge i_clk);
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'hBAD0_BAD0;
    chk("trap_pulse_low", {31'd0, o_trap}, 32'd0);
    chk("valid", {31'd0, o_instr_valid}, 32'd1);
    chk("instr", o_instr, v.rdata);
    chk("pc", o_pc, v.addr);
    chk("pc_four", o_pc_four, v.addr + 32'd4);
    for (int k = 0; k < v.rdy_dly; k++) begin
      i_pc_sel   = 2'b11;
      i_pc_imm   = 32'h0000_0003;
      i_alu_data = 32'h0000_0001;
      @(negedge i_clk);
      chk("valid_stall", {31'd0, o_instr_valid}, 32'd1);
      chk("instr_stall", o_instr, v.rdata);
      chk("pc_stall", o_pc, v.addr);
    end
    i_pc_sel      = v.sel;
    i_pc_imm      = v.imm;
    i_alu_data    = v.alu;
    i_instr_ready = 1'b1;
    @(negedge i_clk);
    i_instr_ready = 1'b0;
    i_pc_sel      = 2'b11;
    i_pc_imm      = 32'h5555_5557;
    i_alu_data    = 32'hAAAA_AAA9;
    if (v.trap) exp_ta = v.taddr;
    chk("trap", {31'd0, o_trap}, {31'd0, v.trap});
    chk("trap_addr", o_trap_addr, exp_ta);
    chk("valid_drop", {31'd0, o_instr_valid}, 32'd0);
    chk("next_req", {31'd0, o_imem_req}, 32'd1);
    chk("next_addr", o_imem_addr, v.nxt);
  endtask

  initial begin
    //          addr          rdata         ad rd sel    imm           alu           nxt           trap  taddr
    vecs[0]  = '{32'h0000_0000, 32'h1111_0000, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0004, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0004, 32'h1111_0004, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0008, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000_0008, 32'h1111_0008, 3, 0, 2'b01, 32'h0000_0100, 32'h0,       32'h0000_0100, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000_0100, 32'h2222_0100, 0, 2, 2'b10, 32'h0,        32'h0000_0203, 32'h0000_0010, 1'b1, 32'h0000_0202};
    vecs[4]  = '{32'h0000_0010, 32'h3333_0010, 1, 0, 2'b01, 32'h0000_0080, 32'h0,       32'h0000_0080, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000_0080, 32'h3333_0080, 0, 0, 2'b01, 32'h0000_0040, 32'h0,       32'h0000_0040, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_0040, 32'h3333_0040, 0, 0, 2'b11, 32'h0000_0044, 32'h0000_0048, 32'h0000_0010, 1'b1, 32'h0000_0040};
    vecs[7]  = '{32'h0000_0010, 32'h4444_0010, 2, 1, 2'b10, 32'h0,        32'h0000_0301, 32'h0000_0300, 1'b0, 32'h0};
    vecs[8]  = '{32'h0000_0300, 32'h4444_0300, 0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h5555_FFFC, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 32'h0};
    vecs[10] = '{32'h0000_0000, 32'h6666_0000, 0, 0, 2'b01, 32'h0000_0022, 32'h0,       32'h0000_0010, 1'b1, 32'h0000_0022};
    vecs[11] = '{32'h0000_0010, 32'h7777_0010, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0000_0014, 1'b0, 32'h0};
    vecs[12] = '{32'h0000_0014, 32'h7777_0014, 0, 0, 2'b01, 32'h0000_0020, 32'h0,       32'h0000_0020, 1'b0, 32'h0};

    i_reset = 1'b0; i_flush = 1'b0; i_pc_sel = 2'b00; i_pc_imm = 32'd0;
    i_alu_data = 32'd0; i_instr_ready = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = 32'd0;
    repeat (2) @(negedge i_clk);
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_trap", {31'd0, o_trap}, 32'd0);
    chk("rst_trap_addr", o_trap_addr, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    i_reset = 1'b1;
    chk("idle_req", {31'd0, o_imem_req}, 32'd0);
    @(negedge i_clk);
    chk("first_req", {31'd0, o_imem_req}, 32'd1);
    chk("first_addr", o_imem_addr, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // flush in FETCH of 0x20 without ack: request held until ack, data dropped
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b1;
    chk("drain_req", {31'd0, o_imem_req}, 32'd1);
    chk("drain_addr", o_imem_addr, 32'h20);
    chk("drain_valid", {31'd0, o_instr_valid}, 32'd0);
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("drain_req2", {31'd0, o_imem_req}, 32'd1);
    chk("drain_addr2", o_imem_addr, 32'h20);
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    chk("drain_no_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("drain_next_req", {31'd0, o_imem_req}, 32'd1);
    chk("drain_next_addr", o_imem_addr, 32'h10);

    // flush and ready together in DELIVER: flush wins, no trap
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_1234;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    chk("fr_valid", {31'd0, o_instr_valid}, 32'd1);
    chk("fr_instr", o_instr, 32'h0000_1234);
    i_flush = 1'b1; i_instr_ready = 1'b1; i_pc_sel = 2'b11;
    @(negedge i_clk);
    i_flush = 1'b0; i_instr_ready = 1'b0; i_pc_sel = 2'b00;
    chk("fr_trap", {31'd0, o_trap}, 32'd0);
    chk("fr_trap_addr", o_trap_addr, exp_ta);
    chk("fr_addr", o_imem_addr, 32'h10);
    chk("fr_req", {31'd0, o_imem_req}, 32'd1);

    // ack and flush together in FETCH of 0x14: drop data, refetch trap vector
    i_imem_ack = 1'b1;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    i_instr_ready = 1'b1; i_pc_sel = 2'b00;
    @(negedge i_clk);
    i_instr_ready = 1'b0;
    chk("af_pre_addr", o_imem_addr, 32'h14);
    i_imem_ack = 1'b1; i_flush = 1'b1; i_imem_rdata = 32'hFEED_FACE;
    @(negedge i_clk);
    i_imem_ack = 1'b0; i_flush = 1'b0;
    chk("af_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("af_req", {31'd0, o_imem_req}, 32'd1);
    chk("af_addr", o_imem_addr, 32'h10);

    // async reset in DRAIN
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("pre_rst_req", {31'd0, o_imem_req}, 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("async_req", {31'd0, o_imem_req}, 32'd0);
    chk("async_valid", {31'd0, o_instr_valid}, 32'd0);
    @(negedge i_clk);
    chk("async_pc", o_pc, 32'd0);
    chk("async_trap_addr", o_trap_addr, 32'd0);
    i_reset = 1'b1;
    exp_ta = 32'd0;
    chk("rel_req", {31'd0, o_imem_req}, 32'd0);
    @(negedge i_clk);
    chk("rel_first_req", {31'd0, o_imem_req}, 32'd1);
    chk("rel_first_addr", o_imem_addr, 32'd0);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0BAD_CAFE;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    chk("rel_instr", o_instr, 32'h0BAD_CAFE);
    chk("rel_pc_four", o_pc_four, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
